// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer with redirect, stall hold and HLT handling.
// Build option FETCH_PERF_CNT_EN adds fetch_wait_cnt, a saturating count of memory wait cycles.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | one-cycle settle after reset, no request
// S_REQ  | fetching from imem_addr; presents captured instruction
// S_HOLD | downstream stalled, current instruction held, no request
// S_HALT | HLT retired; frozen until reset, redirects ignored
module fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_addr,
    input  logic        hlt,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic [15:0] pc_plus2,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0] fetch_wait_cnt,
`endif
    output logic        halted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        halted_q, halted_d;
    logic        capture;
    logic        redirect_take;
    logic        hlt_take;

    always_comb begin
        // A stalled instruction must not be overwritten, so no request is issued under it.
        imem_req      = (state_q == S_REQ) && !(stall && instr_valid_q);
        capture       = imem_req && imem_ready;
        redirect_take = redirect_valid && (state_q != S_HALT);
        hlt_take      = hlt && instr_valid_q && !stall;

        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        if (redirect_take) begin
            pc_d          = redirect_addr & 16'hFFFE;
            instr_valid_d = 1'b0;
            state_d       = S_REQ;
        end else if (hlt_take) begin
            // Any same-cycle fetch is dropped so pc stays on the word after HLT.
            instr_valid_d = 1'b0;
            state_d       = S_HALT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_REQ;
                end
                S_REQ: begin
                    if (capture) begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc_q;
                        pc_d          = pc_q + 16'd2;
                        instr_valid_d = 1'b1;
                        state_d       = stall ? S_HOLD : S_REQ;
                    end else if (instr_valid_q && stall) begin
                        state_d = S_HOLD;
                    end else begin
                        instr_valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        instr_valid_d = 1'b0;
                        state_d       = S_REQ;
                    end
                end
                S_HALT: begin
                    instr_valid_d = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= 16'h0000;
            instr_q       <= 16'h0000;
            instr_pc_q    <= 16'h0000;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc_plus2    = instr_pc_q + 16'd2;
    assign halted      = halted_q;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (imem_req && !imem_ready && (wait_cnt_q != 16'hFFFF)) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= 16'h0000;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign fetch_wait_cnt = wait_cnt_q;
`else
    // Wait-cycle counter is not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vector table, hand-written corner sequences and a random run
// against a flag-level behavioural model of the fetch controller.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_addr = 16'h0000;
    logic        hlt = 1'b0;
    logic        imem_ready = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] pc_plus2;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_wait_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .hlt            (hlt),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .pc_plus2       (pc_plus2),
`ifdef FETCH_PERF_CNT_EN
        .fetch_wait_cnt (fetch_wait_cnt),
`endif
        .halted         (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [15:0] raddr;
        logic        hlt;
        logic        ready;
        logic [15:0] rdata;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [15:0] e_ipc;
        logic [15:0] e_wcnt;
    } vec_t;

    vec_t vecs[15];

    // Behavioural model: "is something presented", "was it held last cycle", pc, halt flag.
    logic        m_idle, m_halted, m_valid, m_held, m_req;
    logic [15:0] m_pc, m_instr, m_ipc, m_wait;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic drive(input logic r, input logic s, input logic rv, input logic [15:0] ra,
                         input logic h, input logic rd, input logic [15:0] rdt);
        @(posedge clk);
        #1;
        rst            = r;
        stall          = s;
        redirect_valid = rv;
        redirect_addr  = ra;
        hlt            = h;
        imem_ready     = rd;
        imem_rdata     = rdt;
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_idle   = 1'b1;
        m_halted = 1'b0;
        m_valid  = 1'b0;
        m_held   = 1'b0;
        m_pc     = 16'h0000;
        m_instr  = 16'h0000;
        m_ipc    = 16'h0000;
        m_wait   = 16'h0000;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else begin
            if (m_req && !imem_ready && m_wait != 16'hFFFF) m_wait = m_wait + 16'd1;
            if (m_halted) begin
                m_valid = 1'b0;
            end else if (redirect_valid) begin
                m_pc    = {redirect_addr[15:1], 1'b0};
                m_valid = 1'b0;
                m_held  = 1'b0;
                m_idle  = 1'b0;
            end else if (hlt && m_valid && !stall) begin
                m_halted = 1'b1;
                m_valid  = 1'b0;
            end else if (m_idle) begin
                m_idle = 1'b0;
            end else if (m_req && imem_ready) begin
                m_instr = imem_rdata;
                m_ipc   = m_pc;
                m_pc    = m_pc + 16'd2;
                m_valid = 1'b1;
                m_held  = stall;
            end else if (m_valid && stall) begin
                m_held = 1'b1;
            end else begin
                m_valid = 1'b0;
                m_held  = 1'b0;
            end
        end
    endtask

    initial begin
        // stall redir raddr hlt ready rdata | req addr valid instr ipc wcnt
        vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'd0};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1002, 1'b1, 16'h0002, 1'b1, 16'h1000, 16'h0000, 16'd0};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h1002, 16'h0002, 16'd0};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b0, 16'h0000, 16'h0000, 16'd1};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b0, 16'h0000, 16'h0000, 16'd2};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1004, 1'b1, 16'h0004, 1'b0, 16'h0000, 16'h0000, 16'd3};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1006, 1'b1, 16'h0006, 1'b1, 16'h1004, 16'h0004, 16'd3};
        vecs[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1008, 1'b0, 16'h0008, 1'b1, 16'h1006, 16'h0006, 16'd3};
        vecs[9]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1008, 1'b0, 16'h0008, 1'b1, 16'h1006, 16'h0006, 16'd3};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1008, 1'b0, 16'h0008, 1'b1, 16'h1006, 16'h0006, 16'd3};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1008, 1'b1, 16'h0008, 1'b0, 16'h0000, 16'h0000, 16'd3};
        vecs[12] = '{1'b0, 1'b1, 16'h0041, 1'b0, 1'b1, 16'h100A, 1'b1, 16'h000A, 1'b1, 16'h1008, 16'h0008, 16'd3};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1040, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0000, 16'd3};
        vecs[14] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0042, 1'b1, 16'h1040, 16'h0040, 16'd3};

        // Reset with a memory response present in the reset cycle; it must be ignored.
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'hDEAD);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'hBEEF);
        chk("rst_req",      16'(imem_req),    16'h0000);
        chk("rst_addr",     imem_addr,        16'h0000);
        chk("rst_valid",    16'(instr_valid), 16'h0000);
        chk("rst_instr",    instr,            16'h0000);
        chk("rst_instr_pc", instr_pc,         16'h0000);
        chk("rst_pc_plus2", pc_plus2,         16'h0002);
        chk("rst_halted",   16'(halted),      16'h0000);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_wait_cnt", fetch_wait_cnt,   16'h0000);
`endif

        for (int i = 0; i < 15; i++) begin
            drive(1'b0, vecs[i].stall, vecs[i].redir, vecs[i].raddr, vecs[i].hlt,
                  vecs[i].ready, vecs[i].rdata);
            chk($sformatf("vec%0d_req", i),   16'(imem_req),    16'(vecs[i].e_req));
            chk($sformatf("vec%0d_addr", i),  imem_addr,        vecs[i].e_addr);
            chk($sformatf("vec%0d_valid", i), 16'(instr_valid), 16'(vecs[i].e_valid));
            chk($sformatf("vec%0d_halt", i),  16'(halted),      16'h0000);
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d_instr", i), instr,    vecs[i].e_instr);
                chk($sformatf("vec%0d_ipc", i),   instr_pc, vecs[i].e_ipc);
                chk($sformatf("vec%0d_pc2", i),   pc_plus2, vecs[i].e_ipc + 16'd2);
            end
`ifdef FETCH_PERF_CNT_EN
            chk($sformatf("vec%0d_wcnt", i), fetch_wait_cnt, vecs[i].e_wcnt);
`endif
        end

        // Wrap: fetch at 0xFFFE, next address rolls over to 0x0000.
        drive(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hABCD);
        chk("wrap_addr_fffe", imem_addr, 16'hFFFE);
        chk("wrap_req",       16'(imem_req), 16'h0001);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("wrap_addr_0",    imem_addr, 16'h0000);
        chk("wrap_valid",     16'(instr_valid), 16'h0001);
        chk("wrap_instr",     instr, 16'hABCD);
        chk("wrap_ipc",       instr_pc, 16'hFFFE);
        chk("wrap_pc_plus2",  pc_plus2, 16'h0000);

        // HLT at 0x0010: halt, redirects ignored, only reset leaves.
        drive(1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hF000);
        chk("hlt_fetch_addr", imem_addr, 16'h0010);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234);
        chk("hlt_presented_pc", instr_pc, 16'h0010);
        chk("hlt_presented_v",  16'(instr_valid), 16'h0001);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b1, 16'h5555);
            chk($sformatf("halt%0d_halted", k), 16'(halted), 16'h0001);
            chk($sformatf("halt%0d_req", k),    16'(imem_req), 16'h0000);
            chk($sformatf("halt%0d_valid", k),  16'(instr_valid), 16'h0000);
            chk($sformatf("halt%0d_addr", k),   imem_addr, 16'h0012);
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("halt_rst_addr",   imem_addr, 16'h0000);
        chk("halt_rst_halted", 16'(halted), 16'h0000);

        // Reset mid-fetch with a same-cycle response.
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("midrst_req_before", 16'(imem_req), 16'h0001);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h7777);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("midrst_valid", 16'(instr_valid), 16'h0000);
        chk("midrst_addr",  imem_addr, 16'h0000);
        chk("midrst_req",   16'(imem_req), 16'h0000);
        chk("midrst_instr", instr, 16'h0000);

        // Random run against the model.
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        model_reset();
        for (int n = 0; n < 4000; n++) begin
            drive(($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 15) == 0),
                  16'($urandom),
                  ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 2) != 0),
                  16'($urandom));
            m_req = !m_idle && !m_halted && !m_held && !(stall && m_valid);
            chk("rnd_req",    16'(imem_req),    16'(m_req));
            chk("rnd_addr",   imem_addr,        m_pc);
            chk("rnd_valid",  16'(instr_valid), 16'(m_valid));
            chk("rnd_halted", 16'(halted),      16'(m_halted));
            if (m_valid) begin
                chk("rnd_instr", instr,    m_instr);
                chk("rnd_ipc",   instr_pc, m_ipc);
                chk("rnd_pc2",   pc_plus2, m_ipc + 16'd2);
            end
`ifdef FETCH_PERF_CNT_EN
            chk("rnd_wcnt", fetch_wait_cnt, m_wait);
`endif
            model_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
